// File: rtl/vehicle_light_controller.sv
// Two-way intersection light controller with queue-sized green times and
// pedestrian-driven green extension of the opposite direction.
module vehicle_light_controller #(
    parameter int MIN_GREEN_CYCLES = 10,
    parameter int MAX_GREEN_CYCLES = 40,
    parameter int EXT_PER_CAR      = 3,
    parameter int YELLOW_CYCLES    = 4,
    parameter int ALL_RED_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        veh_sensor_ns,
    input  logic        veh_sensor_ew,
    input  logic        pd_button_ns,
    input  logic        pd_button_ew,
    output logic        NS_GREEN,
    output logic        NS_YELLOW,
    output logic        NS_RED,
    output logic        EW_GREEN,
    output logic        EW_YELLOW,
    output logic        EW_RED,
    output logic [31:0] ns_green_delay,
    output logic [31:0] ew_green_delay,
    output logic [2:0]  state,
    output logic [31:0] phase_counter
);

    localparam logic [2:0] S_NS_GRN    = 3'd0;
    localparam logic [2:0] S_NS_YEL    = 3'd1;
    localparam logic [2:0] S_ALL_RED_A = 3'd2;
    localparam logic [2:0] S_EW_GRN    = 3'd3;
    localparam logic [2:0] S_EW_YEL    = 3'd4;
    localparam logic [2:0] S_ALL_RED_B = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] phase_counter_q, phase_counter_d;
    logic [31:0] ns_delay_q, ns_delay_d;
    logic [31:0] ew_delay_q, ew_delay_d;
    logic [7:0]  q_ns_q, q_ns_d;
    logic [7:0]  q_ew_q, q_ew_d;
    logic        ped_pend_ns_q, ped_pend_ns_d;
    logic        ped_pend_ew_q, ped_pend_ew_d;
    logic        sens_ns_q, sens_ns_prev_q;
    logic        sens_ew_q, sens_ew_prev_q;

    logic [31:0] dur_s;
    logic        phase_last_s;
    logic        enter_ns_s;
    logic        enter_ew_s;
    logic        edge_ns_s;
    logic        edge_ew_s;

    // Queue-sized green, widened to 40 bits so a large queue cannot wrap,
    // then stretched to half the opposite green when a walk is pending.
    function automatic logic [31:0] green_len(input logic [7:0] q, input logic ped,
                                              input logic [31:0] other);
        logic [39:0] len;
        logic [39:0] half;
        len  = 40'(MIN_GREEN_CYCLES) + (40'(q) * 40'(EXT_PER_CAR));
        half = {9'd0, other[31:1]};
        if (len > 40'(MAX_GREEN_CYCLES)) begin
            len = 40'(MAX_GREEN_CYCLES);
        end else begin
            len = len;
        end
        if (ped && (half > len)) begin
            len = half;
        end else begin
            len = len;
        end
        return len[31:0];
    endfunction

    assign NS_GREEN       = (state_q == S_NS_GRN);
    assign NS_YELLOW      = (state_q == S_NS_YEL);
    assign NS_RED         = ~(NS_GREEN | NS_YELLOW);
    assign EW_GREEN       = (state_q == S_EW_GRN);
    assign EW_YELLOW      = (state_q == S_EW_YEL);
    assign EW_RED         = ~(EW_GREEN | EW_YELLOW);
    assign state          = state_q;
    assign phase_counter  = phase_counter_q;
    assign ns_green_delay = ns_delay_q;
    assign ew_green_delay = ew_delay_q;

    assign edge_ns_s  = sens_ns_q & ~sens_ns_prev_q;
    assign edge_ew_s  = sens_ew_q & ~sens_ew_prev_q;
    assign enter_ns_s = (state_q == S_ALL_RED_B) && phase_last_s;
    assign enter_ew_s = (state_q == S_ALL_RED_A) && phase_last_s;

    // Duration of the current state and phase sequencing.
    always_comb begin
        dur_s           = 32'(ALL_RED_CYCLES);
        state_d         = state_q;
        phase_counter_d = phase_counter_q + 32'd1;
        case (state_q)
            S_NS_GRN:              dur_s = ns_delay_q;
            S_EW_GRN:              dur_s = ew_delay_q;
            S_NS_YEL, S_EW_YEL:    dur_s = 32'(YELLOW_CYCLES);
            default:               dur_s = 32'(ALL_RED_CYCLES);
        endcase
        phase_last_s = (phase_counter_q == (dur_s - 32'd1));
        if (state_q > S_ALL_RED_B) begin
            state_d         = S_ALL_RED_B;
            phase_counter_d = 32'd0;
        end else if (phase_last_s) begin
            phase_counter_d = 32'd0;
            case (state_q)
                S_NS_GRN:    state_d = S_NS_YEL;
                S_NS_YEL:    state_d = S_ALL_RED_A;
                S_ALL_RED_A: state_d = S_EW_GRN;
                S_EW_GRN:    state_d = S_EW_YEL;
                S_EW_YEL:    state_d = S_ALL_RED_B;
                default:     state_d = S_NS_GRN;
            endcase
        end else begin
            phase_counter_d = phase_counter_q + 32'd1;
        end
    end

    // Vehicle queues, pedestrian requests and green-duration loading.
    always_comb begin
        q_ns_d        = q_ns_q;
        q_ew_d        = q_ew_q;
        ns_delay_d    = ns_delay_q;
        ew_delay_d    = ew_delay_q;
        ped_pend_ns_d = pd_button_ns | (ped_pend_ns_q & ~enter_ew_s);
        ped_pend_ew_d = pd_button_ew | (ped_pend_ew_q & ~enter_ns_s);
        if (enter_ns_s) begin
            q_ns_d     = 8'd0;
            ns_delay_d = green_len(q_ns_q, ped_pend_ew_q, ew_delay_q);
        end else if (edge_ns_s && !NS_GREEN && (q_ns_q != 8'hFF)) begin
            q_ns_d = q_ns_q + 8'd1;
        end else begin
            q_ns_d = q_ns_q;
        end
        if (enter_ew_s) begin
            q_ew_d     = 8'd0;
            ew_delay_d = green_len(q_ew_q, ped_pend_ns_q, ns_delay_q);
        end else if (edge_ew_s && !EW_GREEN && (q_ew_q != 8'hFF)) begin
            q_ew_d = q_ew_q + 8'd1;
        end else begin
            q_ew_d = q_ew_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_ALL_RED_B;
            phase_counter_q <= 32'd0;
            ns_delay_q      <= 32'(MIN_GREEN_CYCLES);
            ew_delay_q      <= 32'(MIN_GREEN_CYCLES);
            q_ns_q          <= 8'd0;
            q_ew_q          <= 8'd0;
            ped_pend_ns_q   <= 1'b0;
            ped_pend_ew_q   <= 1'b0;
            sens_ns_q       <= 1'b0;
            sens_ns_prev_q  <= 1'b0;
            sens_ew_q       <= 1'b0;
            sens_ew_prev_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_counter_q <= phase_counter_d;
            ns_delay_q      <= ns_delay_d;
            ew_delay_q      <= ew_delay_d;
            q_ns_q          <= q_ns_d;
            q_ew_q          <= q_ew_d;
            ped_pend_ns_q   <= ped_pend_ns_d;
            ped_pend_ew_q   <= ped_pend_ew_d;
            sens_ns_q       <= veh_sensor_ns;
            sens_ns_prev_q  <= sens_ns_q;
            sens_ew_q       <= veh_sensor_ew;
            sens_ew_prev_q  <= sens_ew_q;
        end
    end

endmodule

// File: tb/tb_vehicle_light_controller.sv
// Directed bench for vehicle_light_controller: a cycle model of the phase
// schedule checked every cycle, plus hand-computed phase lengths and delays.
module tb_vehicle_light_controller;

    localparam int MIN_G = 10;
    localparam int MAX_G = 40;
    localparam int EXT   = 3;
    localparam int YEL   = 4;
    localparam int ARED  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        veh_sensor_ns = 1'b0;
    logic        veh_sensor_ew = 1'b0;
    logic        pd_button_ns = 1'b0;
    logic        pd_button_ew = 1'b0;
    logic        NS_GREEN, NS_YELLOW, NS_RED, EW_GREEN, EW_YELLOW, EW_RED;
    logic [31:0] ns_green_delay, ew_green_delay, phase_counter;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    vehicle_light_controller #(
        .MIN_GREEN_CYCLES(MIN_G), .MAX_GREEN_CYCLES(MAX_G), .EXT_PER_CAR(EXT),
        .YELLOW_CYCLES(YEL), .ALL_RED_CYCLES(ARED)
    ) dut (
        .clk(clk), .rst(rst),
        .veh_sensor_ns(veh_sensor_ns), .veh_sensor_ew(veh_sensor_ew),
        .pd_button_ns(pd_button_ns), .pd_button_ew(pd_button_ew),
        .NS_GREEN(NS_GREEN), .NS_YELLOW(NS_YELLOW), .NS_RED(NS_RED),
        .EW_GREEN(EW_GREEN), .EW_YELLOW(EW_YELLOW), .EW_RED(EW_RED),
        .ns_green_delay(ns_green_delay), .ew_green_delay(ew_green_delay),
        .state(state), .phase_counter(phase_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase index 0..5 in the order NS green, NS yellow, all-red,
    // EW green, EW yellow, all-red; queues counted as plain integers.
    int       m_ph, m_cnt, m_nsd, m_ewd, m_qns, m_qew;
    bit       m_pns, m_pew;
    bit [1:0] h_ns, h_ew;

    function automatic int m_dur(input int ph);
        if (ph == 0) return m_nsd;
        if (ph == 3) return m_ewd;
        if (ph == 1 || ph == 4) return YEL;
        return ARED;
    endfunction

    function automatic int green_len(input int q, input bit ped, input int other);
        int r;
        r = MIN_G + q * EXT;
        if (r > MAX_G) r = MAX_G;
        if (ped && (other / 2) > r) r = other / 2;
        return r;
    endfunction

    function automatic bit m_last();
        return m_cnt == m_dur(m_ph) - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 5; m_cnt <= 0; m_nsd <= MIN_G; m_ewd <= MIN_G;
            m_qns <= 0; m_qew <= 0; m_pns <= 1'b0; m_pew <= 1'b0;
            h_ns <= 2'b00; h_ew <= 2'b00;
        end else begin
            if (m_last() && m_ph == 5) begin
                m_nsd <= green_len(m_qns, m_pew, m_ewd);
                m_qns <= 0;
            end else if (h_ns == 2'b01 && m_ph != 0) begin
                m_qns <= (m_qns < 255) ? m_qns + 1 : 255;
            end
            if (m_last() && m_ph == 2) begin
                m_ewd <= green_len(m_qew, m_pns, m_nsd);
                m_qew <= 0;
            end else if (h_ew == 2'b01 && m_ph != 3) begin
                m_qew <= (m_qew < 255) ? m_qew + 1 : 255;
            end
            m_pns <= pd_button_ns | (m_pns & !(m_last() && m_ph == 2));
            m_pew <= pd_button_ew | (m_pew & !(m_last() && m_ph == 5));
            if (m_last()) begin
                m_ph  <= (m_ph + 1) % 6;
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
            h_ns <= {h_ns[0], veh_sensor_ns};
            h_ew <= {h_ew[0], veh_sensor_ew};
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_ph);
        chk("phase_counter", phase_counter, m_cnt);
        chk("ns_green_delay", ns_green_delay, m_nsd);
        chk("ew_green_delay", ew_green_delay, m_ewd);
        chk("NS_GREEN", NS_GREEN, m_ph == 0);
        chk("NS_YELLOW", NS_YELLOW, m_ph == 1);
        chk("NS_RED", NS_RED, m_ph >= 2);
        chk("EW_GREEN", EW_GREEN, m_ph == 3);
        chk("EW_YELLOW", EW_YELLOW, m_ph == 4);
        chk("EW_RED", EW_RED, !(m_ph == 3 || m_ph == 4));
    end

    task automatic wait_st(input int s, input int pc);
        int n = 0;
        while (!(state == 3'(s) && (pc < 0 || phase_counter == 32'(pc))) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state_timeout", n < 500, 1);
    endtask

    task automatic measure(input string name, input int s, input int exp);
        int len = 0;
        while (state == 3'(s) && len < 200) begin
            len++;
            @(negedge clk);
        end
        chk(name, len, exp);
    endtask

    task automatic pulses(input bit ew, input int n);
        repeat (n) begin
            if (ew) veh_sensor_ew = 1'b1; else veh_sensor_ns = 1'b1;
            @(negedge clk);
            veh_sensor_ew = 1'b0;
            veh_sensor_ns = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_all_red_reset();
        chk("rst_state", state, 5);
        chk("rst_pc", phase_counter, 0);
        chk("rst_lights", {NS_GREEN, NS_YELLOW, NS_RED, EW_GREEN, EW_YELLOW, EW_RED}, 6'b001001);
        chk("rst_ns_delay", ns_green_delay, 10);
        chk("rst_ew_delay", ew_green_delay, 10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_red_reset();
        rst = 1'b0;
        // Idle cycle: all-red 2, green 10, yellow 4, all-red 2 each way.
        measure("idle_allred_b", 5, 2);
        measure("idle_ns_grn", 0, 10);
        measure("idle_ns_yel", 1, 4);
        measure("idle_allred_a", 2, 2);
        measure("idle_ew_grn", 3, 10);
        measure("idle_ew_yel", 4, 4);
        measure("idle_allred_b2", 5, 2);

        // Five NS arrivals during EW green -> 10 + 5*3 = 25.
        wait_st(3, -1);
        pulses(1'b0, 5);
        wait_st(0, -1);
        chk("q5_ns_delay", ns_green_delay, 25);
        measure("q5_ns_grn", 0, 25);
        // Walk request during NS yellow -> EW green max(10, 25/2) = 12.
        pd_button_ns = 1'b1;
        @(negedge clk);
        pd_button_ns = 1'b0;
        wait_st(3, -1);
        chk("ped_ew_delay", ew_green_delay, 12);
        measure("ped_ew_grn", 3, 12);

        // Press in the EW entry cycle stays pending for the following EW green.
        wait_st(2, 1);
        pd_button_ns = 1'b1;
        @(negedge clk);
        pd_button_ns = 1'b0;
        chk("late_ped_ew_delay", ew_green_delay, 10);
        pulses(1'b0, 5);
        wait_st(0, -1);
        chk("late_ped_ns_delay", ns_green_delay, 25);
        wait_st(3, -1);
        chk("late_ped_ew_next", ew_green_delay, 12);
        measure("late_ped_ew_grn", 3, 12);

        // Eight EW arrivals stretch EW to 34, giving room for 20 NS arrivals.
        pulses(1'b1, 8);
        wait_st(1, -1);
        pulses(1'b0, 20);
        chk("ew34_delay", ew_green_delay, 34);
        wait_st(0, -1);
        chk("sat_ns_delay", ns_green_delay, 40);
        measure("sat_ns_grn", 0, 40);

        // Sensor held high across the whole red counts one vehicle -> 13.
        veh_sensor_ns = 1'b1;
        wait_st(0, -1);
        chk("held_ns_delay", ns_green_delay, 13);
        measure("held_ns_grn", 0, 13);
        repeat (15) @(negedge clk);
        veh_sensor_ns = 1'b0;

        // Three EW arrivals, then reset mid NS green at phase_counter 5.
        wait_st(4, -1);
        pulses(1'b1, 3);
        wait_st(0, 5);
        #2 rst = 1'b1;
        #1 chk_all_red_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all_red_reset();
        rst = 1'b0;
        measure("post_rst_allred_b", 5, 2);
        chk("post_rst_ns_delay", ns_green_delay, 10);
        measure("post_rst_ns_grn", 0, 10);
        measure("post_rst_ns_yel", 1, 4);
        measure("post_rst_allred_a", 2, 2);
        chk("post_rst_ew_delay", ew_green_delay, 10);
        measure("post_rst_ew_grn", 3, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
